// File: rtl/secure_comm_pkg.sv
// Shared constants, state encoding and key-word helper for the secure payload link.
`timescale 1ns/1ps
package secure_comm_pkg;

    localparam int BEATS        = 8;
    localparam int WORD_W       = 32;
    localparam int KEY_WORDS    = 4;
    localparam int KEY_W        = KEY_WORDS * WORD_W;
    localparam int PT_W         = BEATS * WORD_W;
    localparam int TAG_KEY_WORD = 3;
    localparam int KS_IDX_W     = 3;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } rx_state_t;

    function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] key, input int j);
        return key[j*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/secure_comm_keystream.sv
// Keystream word for beat index: key word (idx mod 4) XOR the beat index.
// Used by both link ends so their keystreams are bit-identical.
`timescale 1ns/1ps
module secure_comm_keystream
    import secure_comm_pkg::*;
(
    input  logic [KEY_W-1:0]    i_key,
    input  logic [KS_IDX_W-1:0] i_idx,
    output logic [WORD_W-1:0]   o_ks
);

    logic [WORD_W-1:0] w_word;

    // select key word by the low index bits
    always_comb begin
        w_word = '0;
        for (int j = 0; j < KEY_WORDS; j++) begin
            if (i_idx[1:0] == 2'(j)) begin
                w_word = key_word(i_key, j);
            end
        end
    end

    assign o_ks = w_word ^ {{(WORD_W-KS_IDX_W){1'b0}}, i_idx};

endmodule

// File: rtl/secure_comm_rx.sv
// Receive end of the secure payload link: decrypts eight beats into a shadow
// buffer, checks the tag beat, and only exposes plaintext while in HOLD.
//
// state | meaning
// IDLE  | waiting for beat 0 (accepted only once a key is valid)
// RECV  | collecting data beats 1..7 and then the tag beat
// HOLD  | authenticated plaintext presented until the sink consumes it
`timescale 1ns/1ps
module secure_comm_rx
    import secure_comm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_load,
    input  logic              key_zeroize,
    input  logic              rx_valid,
    input  logic [WORD_W-1:0] rx_data,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic              pt_valid,
    output logic [PT_W-1:0]   pt_data,
    input  logic              pt_ready,
    output logic              auth_err,
    output logic              key_valid
);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [KEY_W-1:0]  r_key;
    logic              r_key_valid;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [WORD_W-1:0] r_acc;
    logic [PT_W-1:0]   r_shadow;
    logic              r_auth_err;

    logic              w_rx_ready;
    logic              w_accept;
    logic              w_data_wr;
    logic              w_frame_clr;
    logic              w_err_set;
    logic              w_key_wr;
    logic              w_key_clr;
    logic [WORD_W-1:0] w_ks;
    logic [WORD_W-1:0] w_tag_exp;

    secure_comm_keystream u_keystream (
        .i_key (r_key),
        .i_idx (r_beat_cnt[KS_IDX_W-1:0]),
        .o_ks  (w_ks)
    );

    assign w_tag_exp = r_acc ^ key_word(r_key, TAG_KEY_WORD);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state, handshake and datapath strobes; zeroize overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        w_accept    = 1'b0;
        w_data_wr   = 1'b0;
        w_frame_clr = 1'b0;
        w_err_set   = 1'b0;
        w_key_wr    = 1'b0;
        w_key_clr   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_rx_ready = r_key_valid;
                w_accept   = rx_valid && w_rx_ready;
                if (w_accept) begin
                    if (rx_last) begin
                        w_frame_clr = 1'b1;
                        w_err_set   = 1'b1;
                    end else begin
                        w_data_wr   = 1'b1;
                        w_state_nxt = ST_RECV;
                    end
                end else if (key_load) begin
                    // a load coinciding with beat 0 is dropped so the key stays fixed for the frame
                    w_key_wr = 1'b1;
                end
            end
            ST_RECV: begin
                w_rx_ready = 1'b1;
                w_accept   = rx_valid;
                if (w_accept) begin
                    if (r_beat_cnt == CNT_W'(BEATS)) begin
                        if (!rx_last || (rx_data != w_tag_exp)) begin
                            w_frame_clr = 1'b1;
                            w_err_set   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else if (rx_last) begin
                        w_frame_clr = 1'b1;
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_data_wr = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (pt_ready) begin
                    w_frame_clr = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_frame_clr = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (key_zeroize) begin
            w_state_nxt = ST_IDLE;
            w_data_wr   = 1'b0;
            w_err_set   = 1'b0;
            w_key_wr    = 1'b0;
            w_key_clr   = 1'b1;
            w_frame_clr = 1'b1;
        end
    end

    // session key storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else if (w_key_clr) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else if (w_key_wr) begin
            r_key       <= key_in;
            r_key_valid <= 1'b1;
        end
    end

    // shadow plaintext, tag accumulator and beat counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow   <= '0;
            r_acc      <= '0;
            r_beat_cnt <= '0;
        end else if (w_frame_clr) begin
            r_shadow   <= '0;
            r_acc      <= '0;
            r_beat_cnt <= '0;
        end else if (w_data_wr) begin
            for (int i = 0; i < BEATS; i++) begin
                if (r_beat_cnt[KS_IDX_W-1:0] == KS_IDX_W'(i)) begin
                    r_shadow[i*WORD_W +: WORD_W] <= rx_data ^ w_ks;
                end
            end
            r_acc      <= r_acc ^ rx_data;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

    // one-cycle error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_auth_err <= 1'b0;
        end else begin
            r_auth_err <= w_err_set;
        end
    end

    assign rx_ready  = w_rx_ready;
    assign pt_valid  = (r_state == ST_HOLD);
    assign pt_data   = pt_valid ? r_shadow : '0;
    assign auth_err  = r_auth_err;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_secure_comm_rx.sv
// Directed table-driven bench for secure_comm_rx, plus an async-reset-in-HOLD sequence.
`timescale 1ns/1ps
module tb_secure_comm_rx;

    logic         clk;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         key_zeroize;
    logic         rx_valid;
    logic [31:0]  rx_data;
    logic         rx_last;
    logic         rx_ready;
    logic         pt_valid;
    logic [255:0] pt_data;
    logic         pt_ready;
    logic         auth_err;
    logic         key_valid;

    secure_comm_rx dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .key_load    (key_load),
        .key_zeroize (key_zeroize),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .pt_valid    (pt_valid),
        .pt_data     (pt_data),
        .pt_ready    (pt_ready),
        .auth_err    (auth_err),
        .key_valid   (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [127:0] KEY_K = 128'h08000000_04000000_02000000_01000000;
    localparam logic [255:0] PT_GOOD = {32'h8888888F, 32'h77777771, 32'h66666663, 32'h55555551,
                                        32'h44444447, 32'h33333331, 32'h22222223, 32'h11111111};
    localparam logic [255:0] PT_K    = {32'h8088888F, 32'h73777771, 32'h64666663, 32'h54555551,
                                        32'h4C444447, 32'h37333331, 32'h20222223, 32'h10111111};
    localparam logic [31:0] TAG_Z = 32'h88888888;
    localparam logic [31:0] TAG_K = 32'h80888888;

    typedef struct {
        logic         kl;
        logic         kz;
        logic         v;
        logic         last;
        logic         prdy;
        logic [31:0]  data;
        logic [127:0] key;
        logic         e_rdy;
        logic         e_pv;
        logic         e_err;
        logic         e_kv;
        logic [255:0] e_pt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic logic [31:0] cbeat(input int i);
        return 32'h11111111 * 32'(i + 1);
    endfunction

    function automatic void add(input logic kl, kz, v, last, prdy, input logic [31:0] data,
                                input logic [127:0] key, input logic e_rdy, e_pv, e_err, e_kv,
                                input logic [255:0] e_pt);
        vec_t t;
        t.kl = kl; t.kz = kz; t.v = v; t.last = last; t.prdy = prdy;
        t.data = data; t.key = key;
        t.e_rdy = e_rdy; t.e_pv = e_pv; t.e_err = e_err; t.e_kv = e_kv; t.e_pt = e_pt;
        tbl.push_back(t);
    endfunction

    // data beat i, accepted, frame still in progress
    function automatic void beat(input int i, input logic kl);
        add(kl, 0, 1, 0, 0, cbeat(i), KEY_Z, 1, 0, 0, 1, '0);
    endfunction

    function automatic void beats(input int first, input int n);
        for (int i = first; i < first + n; i++) beat(i, 1'b0);
    endfunction

    // idle cycle with key valid and IDLE state expected afterwards
    function automatic void idle_ok(input logic prdy);
        add(0, 0, 0, 0, prdy, 32'h0, KEY_Z, 1, 0, 0, 1, '0);
    endfunction

    function automatic void good_frame_z();
        beats(0, 8);
        add(0, 0, 1, 1, 0, TAG_Z, KEY_Z, 0, 1, 0, 1, PT_GOOD);
        idle_ok(1'b1);
    endfunction

    task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s vec %0d: got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input int idx, input logic [255:0] act, input logic [255:0] exp);
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        key_load    = t.kl;
        key_zeroize = t.kz;
        rx_valid    = t.v;
        rx_last     = t.last;
        pt_ready    = t.prdy;
        rx_data     = t.data;
        key_in      = t.key;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input vec_t t, input int idx);
        n_vec++;
        chk1("rx_ready", idx, rx_ready, t.e_rdy);
        chk1("pt_valid", idx, pt_valid, t.e_pv);
        chk1("auth_err", idx, auth_err, t.e_err);
        chk1("key_valid", idx, key_valid, t.e_kv);
        chkw("pt_data", idx, pt_data, t.e_pt);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t hv;

        // key load (key = 0)
        add(1, 0, 0, 0, 0, 32'h0, KEY_Z, 1, 0, 0, 1, '0);
        // nominal frame and consumption
        good_frame_z();
        // bad tag, then a good frame
        beats(0, 8);
        add(0, 0, 1, 1, 0, 32'h88888889, KEY_Z, 1, 0, 1, 1, '0);
        idle_ok(1'b0);
        good_frame_z();
        // rx_last on beat 3
        beats(0, 3);
        add(0, 0, 1, 1, 0, cbeat(3), KEY_Z, 1, 0, 1, 1, '0);
        idle_ok(1'b0);
        // good frame then 5 cycles of backpressure with rx_valid held
        beats(0, 8);
        add(0, 0, 1, 1, 0, TAG_Z, KEY_Z, 0, 1, 0, 1, PT_GOOD);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 32'hDEADBEEF, KEY_Z, 0, 1, 0, 1, PT_GOOD);
        idle_ok(1'b1);
        // tag beat without rx_last
        beats(0, 8);
        add(0, 0, 1, 0, 0, TAG_Z, KEY_Z, 1, 0, 1, 1, '0);
        idle_ok(1'b0);
        // zeroize after 4 beats
        beats(0, 4);
        add(0, 1, 1, 0, 0, cbeat(4), KEY_Z, 0, 0, 0, 0, '0);
        add(0, 0, 0, 0, 0, 32'h0, KEY_Z, 0, 0, 0, 0, '0);
        add(0, 0, 1, 0, 0, cbeat(0), KEY_Z, 0, 0, 0, 0, '0);
        // load and zeroize together: zeroize wins
        add(1, 1, 0, 0, 0, 32'h0, KEY_K, 0, 0, 0, 0, '0);
        add(1, 0, 0, 0, 0, 32'h0, KEY_Z, 1, 0, 0, 1, '0);
        good_frame_z();
        // non-zero key; a key_load during RECV must be ignored
        add(1, 0, 0, 0, 0, 32'h0, KEY_K, 1, 0, 0, 1, '0);
        beats(0, 2);
        beat(2, 1'b1);
        beats(3, 5);
        add(0, 0, 1, 1, 0, TAG_K, KEY_Z, 0, 1, 0, 1, PT_K);
        idle_ok(1'b1);

        reset = 1'b0;
        key_in = '0; key_load = 0; key_zeroize = 0;
        rx_valid = 0; rx_data = '0; rx_last = 0; pt_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk1("rst_rx_ready", 0, rx_ready, 1'b0);
        chk1("rst_pt_valid", 0, pt_valid, 1'b0);
        chk1("rst_auth_err", 0, auth_err, 1'b0);
        chk1("rst_key_valid", 0, key_valid, 1'b0);
        chkw("rst_pt_data", 0, pt_data, '0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            check(tbl[i], i + 1);
        end

        // async reset while holding authenticated plaintext (key K still loaded)
        for (int i = 0; i < 8; i++) begin
            hv.kl = 0; hv.kz = 0; hv.v = 1; hv.last = 0; hv.prdy = 0;
            hv.data = cbeat(i); hv.key = KEY_Z;
            drive(hv);
        end
        hv.last = 1; hv.data = TAG_K;
        drive(hv);
        n_vec++;
        chk1("hold_pt_valid", 900, pt_valid, 1'b1);
        chkw("hold_pt_data", 900, pt_data, PT_K);
        rx_valid = 0; rx_last = 0;
        #2;
        reset = 1'b0;
        #0.5;
        n_vec++;
        chk1("arst_pt_valid", 901, pt_valid, 1'b0);
        chkw("arst_pt_data", 901, pt_data, '0);
        chk1("arst_key_valid", 901, key_valid, 1'b0);
        chk1("arst_rx_ready", 901, rx_ready, 1'b0);
        #0.5;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        chk1("post_rst_key_valid", 902, key_valid, 1'b0);
        chk1("post_rst_pt_valid", 902, pt_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
